// File: rtl/scan_chain_reg.sv
// Multi-chain scan register with functional capture, shift counting and an
// optional stuck-at fault overlay on the parallel output and/or scan path.
module scan_chain_reg #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CHAINS         = 2,
  parameter int unsigned INJECT_FAULT   = 0,
  parameter int unsigned FAULT_BIT      = 0,
  parameter int unsigned FAULT_TYPE     = 0,
  parameter int unsigned FAULT_IN_CHAIN = 0,
  localparam int unsigned CLEN          = WIDTH / CHAINS,
  localparam int unsigned CNTW          = $clog2(CLEN + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              scan_en,
  input  logic              capture_en,
  input  logic [CHAINS-1:0] scan_in,
  output logic [CHAINS-1:0] scan_out,
  output logic [WIDTH-1:0]  data_out,
  output logic [CNTW-1:0]   shift_cnt,
  output logic              shift_done
);

  if (WIDTH < 1 || WIDTH > 64) begin : gen_bad_width
    $error("scan_chain_reg: WIDTH must be 1..64");
  end
  if (CHAINS < 1 || CHAINS > WIDTH || (WIDTH % CHAINS) != 0) begin : gen_bad_chains
    $error("scan_chain_reg: CHAINS must divide WIDTH");
  end
  if (FAULT_BIT >= WIDTH) begin : gen_bad_fault_bit
    $error("scan_chain_reg: FAULT_BIT out of range");
  end
  if (FAULT_TYPE > 1) begin : gen_bad_fault_type
    $error("scan_chain_reg: FAULT_TYPE must be 0 or 1");
  end

  localparam bit   FaultOn    = (INJECT_FAULT != 0);
  localparam bit   FaultChain = FaultOn && (FAULT_IN_CHAIN != 0);
  localparam logic FaultVal   = (FAULT_TYPE != 0);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] chain_src;
  logic [WIDTH-1:0] shifted;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;

  // The stuck value only ever corrupts what a flop drives, never what it stores.
  if (FaultChain) begin : gen_chain_fault
    always_comb begin
      chain_src            = reg_q;
      chain_src[FAULT_BIT] = FaultVal;
    end
  end else begin : gen_chain_clean
    assign chain_src = reg_q;
  end

  if (FaultOn) begin : gen_out_fault
    always_comb begin
      data_out            = reg_q;
      data_out[FAULT_BIT] = FaultVal;
    end
  end else begin : gen_out_clean
    assign data_out = reg_q;
  end

  for (genvar c = 0; c < CHAINS; c++) begin : gen_chain
    assign shifted[c*CLEN] = scan_in[c];
    if (CLEN > 1) begin : gen_body
      assign shifted[c*CLEN+1 +: CLEN-1] = chain_src[c*CLEN +: CLEN-1];
    end
    assign scan_out[c] = chain_src[c*CLEN+CLEN-1];
  end

  always_comb begin
    reg_d = reg_q;
    if (scan_en) begin
      reg_d = shifted;
    end else if (capture_en) begin
      reg_d = data_in;
    end
  end

  // Count wraps on the shift that completes a chain length; done is its registered echo.
  always_comb begin
    cnt_d  = '0;
    done_d = 1'b0;
    if (scan_en) begin
      if (cnt_q == CNTW'(CLEN - 1)) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign shift_cnt  = cnt_q;
  assign shift_done = done_q;

endmodule

// File: tb/tb_scan_chain_reg.sv
// Self-checking bench: five scan_chain_reg configurations share stimulus and are
// compared every cycle against a segment-arithmetic reference model.
module tb_scan_chain_reg;

  localparam int NI = 5;
  localparam int W  = 8;
  // Instance configs: 0 clean, 1 fault bit1/0 in chain, 2 fault bit1/0 output only,
  // 3 fault bit7/1 in chain, 4 clean with 8 chains.
  localparam int C_CH[NI]  = '{2, 2, 2, 2, 8};
  localparam int C_INJ[NI] = '{0, 1, 1, 1, 0};
  localparam int C_FB[NI]  = '{0, 1, 1, 7, 0};
  localparam int C_FT[NI]  = '{0, 0, 0, 1, 0};
  localparam int C_FIC[NI] = '{0, 1, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] din = '0;
  logic       se = 1'b0;
  logic       ce = 1'b0;
  logic [1:0] sin2 = '0;
  logic [7:0] sin8 = '0;

  logic [1:0] so0, so1, so2, so3;
  logic [7:0] so4;
  logic [7:0] do0, do1, do2, do3, do4;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;
  logic [0:0] cnt4;
  logic       dn0, dn1, dn2, dn3, dn4;

  logic [63:0] a_do[NI], a_so[NI], a_cnt[NI];
  logic        a_dn[NI];

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_reg[NI];
  int          m_cnt[NI];
  bit          m_dn[NI];

  typedef struct {
    bit         se;
    bit         ce;
    logic [1:0] si;
    logic [7:0] din;
    logic [7:0] e_do;
    logic [1:0] e_so;
    int         e_cnt;
    bit         e_dn;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  scan_chain_reg u_dut (
    .clk(clk), .rstn(rstn), .data_in(din), .scan_en(se), .capture_en(ce),
    .scan_in(sin2), .scan_out(so0), .data_out(do0), .shift_cnt(cnt0), .shift_done(dn0)
  );
  scan_chain_reg #(.INJECT_FAULT(1), .FAULT_BIT(1), .FAULT_TYPE(0), .FAULT_IN_CHAIN(1)) u_fic (
    .clk(clk), .rstn(rstn), .data_in(din), .scan_en(se), .capture_en(ce),
    .scan_in(sin2), .scan_out(so1), .data_out(do1), .shift_cnt(cnt1), .shift_done(dn1)
  );
  scan_chain_reg #(.INJECT_FAULT(1), .FAULT_BIT(1), .FAULT_TYPE(0), .FAULT_IN_CHAIN(0)) u_foc (
    .clk(clk), .rstn(rstn), .data_in(din), .scan_en(se), .capture_en(ce),
    .scan_in(sin2), .scan_out(so2), .data_out(do2), .shift_cnt(cnt2), .shift_done(dn2)
  );
  scan_chain_reg #(.INJECT_FAULT(1), .FAULT_BIT(7), .FAULT_TYPE(1), .FAULT_IN_CHAIN(1)) u_f1 (
    .clk(clk), .rstn(rstn), .data_in(din), .scan_en(se), .capture_en(ce),
    .scan_in(sin2), .scan_out(so3), .data_out(do3), .shift_cnt(cnt3), .shift_done(dn3)
  );
  scan_chain_reg #(.WIDTH(8), .CHAINS(8)) u_c8 (
    .clk(clk), .rstn(rstn), .data_in(din), .scan_en(se), .capture_en(ce),
    .scan_in(sin8), .scan_out(so4), .data_out(do4), .shift_cnt(cnt4), .shift_done(dn4)
  );

  assign a_do[0] = 64'(do0);
  assign a_do[1] = 64'(do1);
  assign a_do[2] = 64'(do2);
  assign a_do[3] = 64'(do3);
  assign a_do[4] = 64'(do4);
  assign a_so[0] = 64'(so0);
  assign a_so[1] = 64'(so1);
  assign a_so[2] = 64'(so2);
  assign a_so[3] = 64'(so3);
  assign a_so[4] = 64'(so4);
  assign a_cnt[0] = 64'(cnt0);
  assign a_cnt[1] = 64'(cnt1);
  assign a_cnt[2] = 64'(cnt2);
  assign a_cnt[3] = 64'(cnt3);
  assign a_cnt[4] = 64'(cnt4);
  assign a_dn[0] = dn0;
  assign a_dn[1] = dn1;
  assign a_dn[2] = dn2;
  assign a_dn[3] = dn3;
  assign a_dn[4] = dn4;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Register as seen by a consumer; chain view honours the in-chain flag only.
  function automatic logic [63:0] m_view(int k, logic [63:0] r, bit chain);
    logic [63:0] v = r;
    if (C_INJ[k] != 0 && (!chain || C_FIC[k] != 0)) begin
      if (C_FT[k] != 0) v = v | (64'd1 << C_FB[k]);
      else              v = v & ~(64'd1 << C_FB[k]);
    end
    return v;
  endfunction

  function automatic logic [63:0] m_sout(int k);
    int          clen = W / C_CH[k];
    logic [63:0] e = m_view(k, m_reg[k], 1'b1);
    logic [63:0] s = '0;
    for (int c = 0; c < C_CH[k]; c++) begin
      s = s | (((e >> (c * clen + clen - 1)) & 64'd1) << c);
    end
    return s;
  endfunction

  task automatic model_edge(input int k, input bit s_e, input bit c_e,
                            input logic [63:0] s_in, input logic [63:0] d);
    int          clen = W / C_CH[k];
    logic [63:0] mask = (64'd1 << clen) - 64'd1;
    logic [63:0] e = m_view(k, m_reg[k], 1'b1);
    logic [63:0] nr = '0;
    logic [63:0] seg;
    if (s_e) begin
      for (int c = 0; c < C_CH[k]; c++) begin
        seg = (e >> (c * clen)) & mask;
        seg = ((seg << 1) | ((s_in >> c) & 64'd1)) & mask;
        nr  = nr | (seg << (c * clen));
      end
      m_reg[k] = nr;
      if (m_cnt[k] + 1 == clen) begin
        m_cnt[k] = 0;
        m_dn[k]  = 1'b1;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        m_dn[k]  = 1'b0;
      end
    end else begin
      if (c_e) m_reg[k] = d & 64'hFF;
      m_cnt[k] = 0;
      m_dn[k]  = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_reg[k] = '0;
      m_cnt[k] = 0;
      m_dn[k]  = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("data_out[%0d]", k), a_do[k], m_view(k, m_reg[k], 1'b0));
      chk($sformatf("scan_out[%0d]", k), a_so[k], m_sout(k));
      chk($sformatf("shift_cnt[%0d]", k), a_cnt[k], 64'(m_cnt[k]));
      chk($sformatf("shift_done[%0d]", k), 64'(a_dn[k]), 64'(m_dn[k]));
    end
  endtask

  task automatic step(input bit s_e, input bit c_e, input logic [1:0] s2,
                      input logic [7:0] s8, input logic [7:0] d);
    se   = s_e;
    ce   = c_e;
    sin2 = s2;
    sin8 = s8;
    din  = d;
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      model_edge(k, s_e, c_e, (k == 4) ? 64'(s8) : 64'(s2), 64'(d));
    end
    @(negedge clk);
    compare_all();
  endtask

  // Called at a falling edge; reset is pulsed between clock edges.
  task automatic rst_pulse();
    rstn = 1'b0;
    #2;
    model_reset();
    compare_all();
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 2'b00, 8'hA5, 8'hA5, 2'b10, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h4B, 2'b01, 1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h86, 2'b10, 2, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 2'b11, 8'h00, 8'h1D, 2'b01, 3, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h2B, 2'b01, 0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 2'b11, 8'h33, 8'h2B, 2'b01, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 2'b11, 0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 2'b00, 8'h00, 8'hEE, 2'b11, 1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 2'b00, 8'h00, 8'hEE, 2'b11, 0, 1'b0};

    // Power-on reset, checked before any clock edge is released.
    #1 rstn = 1'b0;
    #2;
    model_reset();
    compare_all();
    chk("rst_do_f1", 64'(do3), 64'h80);
    chk("rst_so_f1", 64'(so3), 64'h2);
    chk("rst_do_clean", 64'(do0), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;

    // Capture, full load, hold, and shift-beats-capture.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].se, tbl[i].ce, tbl[i].si, 8'h00, tbl[i].din);
      chk($sformatf("tbl%0d_do", i), 64'(do0), 64'(tbl[i].e_do));
      chk($sformatf("tbl%0d_so", i), 64'(so0), 64'(tbl[i].e_so));
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt0), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_done", i), 64'(dn0), 64'(tbl[i].e_dn));
    end

    // Reset in the middle of a load: counting and contents restart cleanly.
    @(negedge clk);
    rst_pulse();
    step(1'b1, 1'b0, 2'b10, 8'h00, 8'h00);
    step(1'b1, 1'b0, 2'b10, 8'h00, 8'h00);
    rst_pulse();
    chk("midrst_do", 64'(do0), 64'h0);
    chk("midrst_cnt", 64'(cnt0), 64'h0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00);
      chk($sformatf("midrst_done%0d", i), 64'(dn0), (i == 4) ? 64'h1 : 64'h0);
      if (i == 2) chk("midrst_do2", 64'(do0), 64'h03);
    end
    chk("midrst_do4", 64'(do0), 64'h0F);

    // Stuck-at-0 on bit 1: in-chain blocks the ones, output-only does not.
    rst_pulse();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00);
    chk("fic_load", 64'(do1[3:0]), 64'h1);
    chk("foc_load", 64'(do2[3:0]), 64'hD);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("foc_unload%0d", i), 64'(so2[0]), 64'h1);
      chk($sformatf("fic_unload%0d", i), 64'(so1[0]), 64'h0);
      step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    end

    // One-bit chains: every shift completes a chain.
    rst_pulse();
    step(1'b1, 1'b0, 2'b00, 8'hFF, 8'h00);
    chk("c8_do", 64'(do4), 64'hFF);
    chk("c8_done", 64'(dn4), 64'h1);
    chk("c8_cnt", 64'(cnt4), 64'h0);
    step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    chk("c8_done_clr", 64'(dn4), 64'h0);

    // Randomised traffic against the model, with occasional asynchronous resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 49) == 0) rst_pulse();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           2'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
